// File: rtl/lsq_pkg.sv
// rtl/lsq_pkg.sv - shared LSQ types: controller FSM states, entry struct, opcodes
package lsq_pkg;

   // Default widths of an LSQ entry as seen by the queue itself
   localparam int LSQ_PC_WIDTH   = 12;
   localparam int LSQ_ADDR_WIDTH = 32;
   localparam int LSQ_DATA_WIDTH = 32;

   // is_load encoding used by both the queue and the memory controller
   localparam logic OP_STORE = 1'b0;
   localparam logic OP_LOAD  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_WB   = 2'd3
   } lsq_state_e;

   typedef struct packed {
      logic                      is_load;
      logic [LSQ_PC_WIDTH-1:0]   pc;
      logic [LSQ_ADDR_WIDTH-1:0] addr;
      logic [LSQ_DATA_WIDTH-1:0] data;
   } lsq_entry_t;

   // Word accesses only: any set bit in the two low address bits is a fault
   function automatic logic addr_misaligned(input logic [1:0] low_bits);
      return low_bits != 2'b00;
   endfunction

endpackage

// File: rtl/lsq_mem_timer.sv
// rtl/lsq_mem_timer.sv - load response watchdog, counts cycles while start is high
module lsq_mem_timer #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic clear,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt;

   // Fires on the last waiting cycle so the owner leaves exactly TIMEOUT_CYCLES after entry
   assign expired = start && (cnt == CW'(TIMEOUT_CYCLES - 1));

   // Cycle counter: cleared on entry to the wait, saturates once expired
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (start && !expired) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/lsq_mem_ctrl.sv
// rtl/lsq_mem_ctrl.sv - LSQ head-entry memory controller; optional watchdog via LSQ_MEM_TIMEOUT_EN
module lsq_mem_ctrl
   import lsq_pkg::*;
#(
   parameter int PC_WIDTH       = 12,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ent_valid,
   output logic                  ent_ready,
   input  logic                  ent_is_load,
   input  logic [PC_WIDTH-1:0]   ent_pc,
   input  logic [ADDR_WIDTH-1:0] ent_addr,
   input  logic [DATA_WIDTH-1:0] ent_data,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  wb_valid,
   input  logic                  wb_ready,
   output logic [PC_WIDTH-1:0]   wb_pc,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic                  wb_is_load,
   output logic                  wb_err
);

   lsq_state_e            state_q, state_d;
   logic                  is_load_q;
   logic                  we_q;
   logic [PC_WIDTH-1:0]   pc_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [DATA_WIDTH-1:0] wb_data_q;
   logic                  wb_err_q;
   logic                  timeout;

`ifdef LSQ_MEM_TIMEOUT_EN
   lsq_mem_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .start   (state_q == ST_WAIT),
      .clear   ((state_q == ST_REQ) && mem_req_ready),
      .expired (timeout)
   );
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign timeout = 1'b0;
`endif

   // Next-state logic; a response is only honoured once the FSM is in WAIT
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (ent_valid) state_d = addr_misaligned(ent_addr[1:0]) ? ST_WB : ST_REQ;
         ST_REQ:  if (mem_req_ready) state_d = is_load_q ? ST_WAIT : ST_WB;
         ST_WAIT: if (mem_rvalid || timeout) state_d = ST_WB;
         ST_WB:   if (wb_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State register and the latched entry / completion payload
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         is_load_q <= 1'b0;
         we_q      <= 1'b0;
         pc_q      <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         wb_data_q <= '0;
         wb_err_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (ent_valid) begin
                  is_load_q <= ent_is_load;
                  we_q      <= (ent_is_load == OP_STORE);
                  pc_q      <= ent_pc;
                  addr_q    <= ent_addr;
                  data_q    <= (ent_is_load == OP_LOAD) ? '0 : ent_data;
                  wb_data_q <= '0;
                  wb_err_q  <= addr_misaligned(ent_addr[1:0]);
               end
            end
            ST_WAIT: begin
               if (mem_rvalid) begin
                  wb_data_q <= mem_rdata;
               end else if (timeout) begin
                  wb_err_q  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign ent_ready     = (state_q == ST_IDLE) && !rst;
   assign mem_req_valid = (state_q == ST_REQ);
   assign mem_we        = we_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = data_q;
   assign wb_valid      = (state_q == ST_WB);
   assign wb_pc         = pc_q;
   assign wb_data       = wb_data_q;
   assign wb_is_load    = is_load_q;
   assign wb_err        = wb_err_q;

endmodule

// File: tb/tb_lsq_mem_ctrl.sv
// tb/tb_lsq_mem_ctrl.sv - self-checking bench for lsq_mem_ctrl (default build or LSQ_MEM_TIMEOUT_EN)
module tb_lsq_mem_ctrl;

   localparam int PCW = 12;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TO  = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic           ent_valid, ent_ready, ent_is_load;
   logic [PCW-1:0] ent_pc;
   logic [AW-1:0]  ent_addr;
   logic [DW-1:0]  ent_data;
   logic           mem_req_valid, mem_req_ready, mem_we;
   logic [AW-1:0]  mem_addr;
   logic [DW-1:0]  mem_wdata;
   logic           mem_rvalid;
   logic [DW-1:0]  mem_rdata;
   logic           wb_valid, wb_ready, wb_is_load, wb_err;
   logic [PCW-1:0] wb_pc;
   logic [DW-1:0]  wb_data;

   int n_checks = 0;
   int n_errors = 0;

   // Reference memory: stores update it, loads expect its contents
   logic [DW-1:0] mem_model [logic [AW-1:0]];

   lsq_mem_ctrl #(
      .PC_WIDTH (PCW), .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk (clk), .rst (rst),
      .ent_valid (ent_valid), .ent_ready (ent_ready), .ent_is_load (ent_is_load),
      .ent_pc (ent_pc), .ent_addr (ent_addr), .ent_data (ent_data),
      .mem_req_valid (mem_req_valid), .mem_req_ready (mem_req_ready), .mem_we (mem_we),
      .mem_addr (mem_addr), .mem_wdata (mem_wdata),
      .mem_rvalid (mem_rvalid), .mem_rdata (mem_rdata),
      .wb_valid (wb_valid), .wb_ready (wb_ready), .wb_pc (wb_pc), .wb_data (wb_data),
      .wb_is_load (wb_is_load), .wb_err (wb_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
   endfunction

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
      chk({tag, "_wb_valid"},      wb_valid,      0);
      chk({tag, "_wb_err"},        wb_err,        0);
      chk({tag, "_mem_we"},        mem_we,        0);
      chk({tag, "_mem_addr"},      mem_addr,      0);
      chk({tag, "_mem_wdata"},     mem_wdata,     0);
      chk({tag, "_wb_pc"},         wb_pc,         0);
      chk({tag, "_wb_data"},       wb_data,       0);
   endtask

   // One full entry from acceptance to completion; called at a negedge with the DUT idle
   task automatic run_entry(input logic ld, input logic [PCW-1:0] pc, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input int req_dly, input int rv_dly,
                            input int wb_dly, input bit rv_with_ready);
      logic [DW-1:0] exp_data;
      bit            mis;
      mis      = (addr[1:0] != 2'b00);
      exp_data = (!mis && ld) ? mem_read(addr) : '0;
      chk("ent_ready_idle", ent_ready, 1);
      ent_valid = 1; ent_is_load = ld; ent_pc = pc; ent_addr = addr; ent_data = data;
      tick();
      ent_valid = 0; ent_addr = $urandom; ent_data = $urandom; ent_pc = PCW'($urandom);
      if (!mis) begin
         for (int k = 0; k <= req_dly; k++) begin
            chk("req_valid", mem_req_valid, 1);
            chk("req_we", mem_we, !ld);
            chk("req_addr", mem_addr, addr);
            if (!ld) chk("req_wdata", mem_wdata, data);
            chk("ent_ready_busy", ent_ready, 0);
            mem_req_ready = (k == req_dly);
            mem_rvalid    = rv_with_ready && (k == req_dly);
            mem_rdata     = ~exp_data;
            wb_ready      = 1'($urandom_range(0, 1));
            tick();
         end
         mem_req_ready = 0; mem_rvalid = 0;
         if (ld) begin
            for (int j = 0; j < rv_dly; j++) begin
               chk("wait_no_wb", wb_valid, 0);
               chk("wait_no_req", mem_req_valid, 0);
               tick();
            end
            mem_rvalid = 1; mem_rdata = exp_data;
            tick();
            mem_rvalid = 0; mem_rdata = $urandom;
         end else begin
            mem_model[addr] = data;
         end
         wb_ready = 0;
      end else begin
         chk("mis_no_req", mem_req_valid, 0);
      end
      for (int w = 0; w <= wb_dly; w++) begin
         chk("wb_valid", wb_valid, 1);
         chk("wb_pc", wb_pc, pc);
         chk("wb_data", wb_data, exp_data);
         chk("wb_is_load", wb_is_load, ld);
         chk("wb_err", wb_err, mis);
         chk("wb_ent_ready", ent_ready, 0);
         chk("wb_no_req", mem_req_valid, 0);
         wb_ready   = (w == wb_dly);
         ent_valid  = 1;
         mem_rvalid = 1'($urandom_range(0, 1));
         mem_rdata  = $urandom;
         tick();
      end
      ent_valid = 0; wb_ready = 0; mem_rvalid = 0;
      chk("post_wb_idle", ent_ready, 1);
      chk("post_wb_no_wb", wb_valid, 0);
   endtask

   initial begin
      logic [AW-1:0] ra;
      logic          rl;
      rst = 1; ent_valid = 0; ent_is_load = 0; ent_pc = '0; ent_addr = '0; ent_data = '0;
      mem_req_ready = 0; mem_rvalid = 0; mem_rdata = '0; wb_ready = 0;
      tick(); tick();
      chk("rst_ent_ready", ent_ready, 0);
      chk_reset_outputs("rst");
      rst = 0;
      tick();
      chk("rst_release_ent_ready", ent_ready, 1);

      // Directed: aligned store, stalled load, misaligned load, back-to-back with slow consumer
      run_entry(1'b0, 12'h010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0);
      mem_model[32'h104] = 32'h12345678;
      run_entry(1'b1, 12'h011, 32'h104, 32'h0, 3, 2, 0, 1);
      run_entry(1'b1, 12'h012, 32'h102, 32'h0, 0, 0, 1, 0);
      run_entry(1'b0, 12'h020, 32'h200, 32'hCAFEF00D, 1, 0, 5, 0);
      run_entry(1'b1, 12'h021, 32'h200, 32'h0, 0, 1, 5, 0);

      // Reset while waiting for the load response drops the transaction
      ent_valid = 1; ent_is_load = 1; ent_pc = 12'h030; ent_addr = 32'h300; ent_data = '0;
      tick();
      ent_valid = 0; mem_req_ready = 1;
      tick();
      mem_req_ready = 0;
      tick();
      chk("pre_rst_wait_no_wb", wb_valid, 0);
      rst = 1;
      tick();
      chk("midrst_ent_ready", ent_ready, 0);
      chk_reset_outputs("midrst");
      rst = 0;
      tick();
      chk("midrst_idle", ent_ready, 1);
      mem_rvalid = 1; mem_rdata = 32'h55AA55AA;
      tick();
      mem_rvalid = 0;
      for (int i = 0; i < 3; i++) begin
         chk("late_rvalid_no_wb", wb_valid, 0);
         chk("late_rvalid_no_req", mem_req_valid, 0);
         tick();
      end

      // Load with no response at all
      ent_valid = 1; ent_is_load = 1; ent_pc = 12'h040; ent_addr = 32'h400;
      tick();
      ent_valid = 0; mem_req_ready = 1;
      tick();
      mem_req_ready = 0;
`ifdef LSQ_MEM_TIMEOUT_EN
      for (int i = 0; i < TO; i++) begin
         chk("to_waiting", wb_valid, 0);
         tick();
      end
      chk("to_wb_valid", wb_valid, 1);
      chk("to_wb_err", wb_err, 1);
      chk("to_wb_data", wb_data, 0);
      mem_rvalid = 1; mem_rdata = 32'h77777777;
      tick();
      mem_rvalid = 0;
      chk("to_stray_rvalid", wb_data, 0);
      wb_ready = 1;
      tick();
      wb_ready = 0;
`else
      for (int i = 0; i < 100; i++) begin
         chk("wait_forever", {wb_valid, mem_req_valid, ent_ready}, 3'b000);
         tick();
      end
      mem_rvalid = 1; mem_rdata = 32'h0BADCAFE;
      tick();
      mem_rvalid = 0;
      chk("late_load_wb_valid", wb_valid, 1);
      chk("late_load_wb_data", wb_data, 32'h0BADCAFE);
      chk("late_load_wb_err", wb_err, 0);
      wb_ready = 1;
      tick();
      wb_ready = 0;
`endif
      chk("after_no_rsp_idle", ent_ready, 1);

      // Randomized entries against the reference memory
      for (int n = 0; n < 40; n++) begin
         rl = 1'($urandom_range(0, 1));
         ra = 32'h1000 + (AW'($urandom_range(0, 15)) << 2);
         if ($urandom_range(0, 4) == 0) ra[1:0] = 2'($urandom_range(1, 3));
         run_entry(rl, PCW'($urandom), ra, $urandom, $urandom_range(0, 3),
                   $urandom_range(0, 5), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
